cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Parametrised, buffered common data bus that replaces the single-source combinational CDB packet former.
- NUM_SRC functional units deposit results into per-source FIFOs.
- A round-robin arbiter selects up to NUM_LANES results per cycle and drives them onto registered broadcast lanes read by the RS, ROB and map table.
- Mispredict squash flushes all buffered and in-flight results.

Parameters:
- NUM_SRC, 4, number of functional-unit result sources (>=2)
- NUM_LANES, 2, broadcast lanes per cycle (1..NUM_SRC)
- BUF_DEPTH, 2, entries per source FIFO (>=1)
- TAG_W, 6, physical register tag width
- XLEN, 32, result value width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  mispredict flush; acts at next rising edge
- src_valid  in  NUM_SRC  source i offers a result this cycle
- src_tag  in  NUM_SRC*TAG_W  destination tag per source
- src_value  in  NUM_SRC*XLEN  result value per source
- src_no_output  in  NUM_SRC  result writes no register (store, branch)
- src_ready  out  NUM_SRC  source FIFO can accept this cycle
- cdb_valid  out  NUM_LANES  lane carries a result
- cdb_tag  out  NUM_LANES*TAG_W  broadcast tag
- cdb_value  out  NUM_LANES*XLEN  broadcast value
- cdb_reg_valid  out  NUM_LANES  lane writes a register
- cdb_src  out  NUM_LANES*$clog2(NUM_SRC)  source index of lane

Behaviour:
- Reset values: all FIFOs empty, rr_ptr=0, every cdb_* output 0. src_ready is all-ones in the first cycle after reset.
- Handshake: a push occurs when src_valid[i] && src_ready[i]. src_valid is ignored while src_ready=0; the source must hold it.
- src_ready[i] = (count_i < BUF_DEPTH). It depends on state only, not on the same-cycle grant; there is no pop-enables-push pass-through.
- FIFOs: each is a circular buffer with head/tail pointers wrapping at BUF_DEPTH. Per cycle there is at most one push and one pop per source.
  - A simultaneous push and pop leaves count unchanged.
  - A pop from an empty FIFO is impossible by construction.
- Arbitration: combinational each cycle over non-empty FIFO heads.
  - Scan sources in order rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - Grant the first min(NUM_LANES, nonempty) sources. Each source receives at most one grant per cycle.
  - Granted heads pop at the edge.
- Lane assignment: the k-th granted source in scan order drives lane k. Lanes are packed from lane 0, with no holes.
- rr_ptr update: becomes (last granted source + 1) mod NUM_SRC; unchanged if nothing is granted.
- Output register: lanes are registered. Lane k is valid iff grant k existed in the previous cycle.
  - Invalid lanes drive tag, value, reg_valid and src as 0.
- cdb_reg_valid[k] = cdb_valid[k] && !no_output && (tag != 0). Tag 0 is the zero register.
- Latency: a push at edge t is eligible in cycle t+1 and appears on the CDB in the cycle after edge t+1 (minimum 2 cycles, src_valid to cdb_valid). There is no bypass.
- Throughput: NUM_LANES results per cycle sustained when >= NUM_LANES sources are backlogged.
- Fairness: a backlogged source waits at most ceil(NUM_SRC/NUM_LANES)-1 cycles between grants.
- squash: at the edge, all FIFOs empty, all cdb_valid are cleared, and pushes in that cycle are dropped (no write).
  - Grants in the squash cycle are discarded.
  - rr_ptr is unchanged.
  - src_ready is all-ones the following cycle.
- reset has priority over squash; mid-operation reset discards everything, including the lane outputs, at that edge.
- Lane outputs depend only on registered state; no combinational input-to-output path exists on the cdb_* outputs.

Test Plan:
- Single result: reset, then src 2 pushes tag=5, val=0xDEAD at edge 1 -> cdb_valid=01, cdb_tag[0]=5, cdb_value[0]=0xDEAD, cdb_src[0]=2, reg_valid=1 after edge 2; lanes idle after edge 3.
- Contention: all 4 sources push once at edge 1 (tags 1..4), rr_ptr=0 -> after edge 2 lanes carry srcs {0,1}; after edge 3, srcs {2,3}; rr_ptr=0 after edge 3.
- Backpressure: BUF_DEPTH=2, src 0 pushes 3 consecutive cycles while srcs 1–3 are kept saturated so src 0 loses arbitration -> src_ready[0]=0 after 2 entries; the third result is held until space frees; all three broadcast in push order.
- Zero register and no_output: tag=0 push -> cdb_valid=1 with reg_valid=0; no_output=1 with tag=9 -> cdb_valid=1 with reg_valid=0.
- Squash: 3 entries buffered, squash asserted with a same-cycle push -> the next cycle has cdb_valid=0, all src_ready=1, and the squashed entries never appear.
- Reset mid-burst: reset asserted while both lanes are valid -> all outputs 0 at the next edge, FIFOs empty, rr_ptr=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Buffered common data bus: per-source result FIFOs feed a round-robin arbiter
// that drives up to NUM_LANES registered broadcast lanes each cycle.
module cdb_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int NUM_LANES = 2,
  parameter int BUF_DEPTH = 2,
  parameter int TAG_W     = 6,
  parameter int XLEN      = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                squash,
  input  logic [NUM_SRC-1:0]                  src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]            src_tag,
  input  logic [NUM_SRC*XLEN-1:0]             src_value,
  input  logic [NUM_SRC-1:0]                  src_no_output,
  output logic [NUM_SRC-1:0]                  src_ready,
  output logic [NUM_LANES-1:0]                cdb_valid,
  output logic [NUM_LANES*TAG_W-1:0]          cdb_tag,
  output logic [NUM_LANES*XLEN-1:0]           cdb_value,
  output logic [NUM_LANES-1:0]                cdb_reg_valid,
  output logic [NUM_LANES*$clog2(NUM_SRC)-1:0] cdb_src
);

  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int ENT_W  = TAG_W + XLEN + 1;

  // Entry layout: {no_output, tag, value}
  logic [ENT_W-1:0]     mem      [NUM_SRC][BUF_DEPTH];
  logic [PTR_W-1:0]     head     [NUM_SRC];
  logic [PTR_W-1:0]     tail     [NUM_SRC];
  logic [CNT_W-1:0]     count    [NUM_SRC];
  logic [ENT_W-1:0]     head_ent [NUM_SRC];
  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     rr_next;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   grant;
  logic [SRC_W-1:0]     lane_sel [NUM_LANES];
  logic [NUM_LANES-1:0] lane_vld;

  logic [NUM_LANES-1:0]       valid_nxt;
  logic [NUM_LANES*TAG_W-1:0] tag_nxt;
  logic [NUM_LANES*XLEN-1:0]  value_nxt;
  logic [NUM_LANES-1:0]       reg_valid_nxt;
  logic [NUM_LANES*SRC_W-1:0] src_nxt;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Readiness comes from occupancy alone, so a same-cycle pop never frees a slot early
  always_comb begin
    src_ready = '0;
    push      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      head_ent[i]  = mem[i][head[i]];
      src_ready[i] = (count[i] < CNT_W'(BUF_DEPTH));
      push[i]      = src_valid[i] && src_ready[i] && !squash;
    end
  end

  always_comb begin
    int s;
    int n;
    grant    = '0;
    lane_vld = '0;
    rr_next  = rr_ptr;
    s        = 0;
    n        = 0;
    for (int k = 0; k < NUM_LANES; k++) lane_sel[k] = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      s = int'(rr_ptr) + j;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      if (count[SRC_W'(s)] != '0 && n < NUM_LANES) begin
        grant[SRC_W'(s)]     = 1'b1;
        lane_sel[LANE_W'(n)] = SRC_W'(s);
        lane_vld[LANE_W'(n)] = 1'b1;
        rr_next              = (s == NUM_SRC - 1) ? '0 : SRC_W'(s + 1);
        n                    = n + 1;
      end
    end
  end

  always_comb begin
    valid_nxt     = lane_vld;
    tag_nxt       = '0;
    value_nxt     = '0;
    reg_valid_nxt = '0;
    src_nxt       = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_vld[k]) begin
        tag_nxt[k*TAG_W +: TAG_W] = head_ent[lane_sel[k]][XLEN +: TAG_W];
        value_nxt[k*XLEN +: XLEN] = head_ent[lane_sel[k]][XLEN-1:0];
        src_nxt[k*SRC_W +: SRC_W] = lane_sel[k];
        reg_valid_nxt[k]          = !head_ent[lane_sel[k]][ENT_W-1] &&
                                    (head_ent[lane_sel[k]][XLEN +: TAG_W] != '0);
      end
    end
  end

  // Squash drops buffered entries and this cycle's grants but keeps the fairness pointer
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      cdb_valid     <= '0;
      cdb_tag       <= '0;
      cdb_value     <= '0;
      cdb_reg_valid <= '0;
      cdb_src       <= '0;
    end else begin
      cdb_valid     <= valid_nxt;
      cdb_tag       <= tag_nxt;
      cdb_value     <= value_nxt;
      cdb_reg_valid <= reg_valid_nxt;
      cdb_src       <= src_nxt;
    end
    if (reset) rr_ptr <= '0;
    else if (!squash) rr_ptr <= rr_next;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reset || squash) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end else begin
        if (push[i]) begin
          mem[i][tail[i]] <= {src_no_output[i], src_tag[i*TAG_W +: TAG_W],
                              src_value[i*XLEN +: XLEN]};
          tail[i]         <= bump(tail[i]);
        end
        if (grant[i]) head[i] <= bump(head[i]);
        if (push[i] && !grant[i]) count[i] <= count[i] + 1'b1;
        else if (!push[i] && grant[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

endmodule
